flash_read_detector: RTL

- Read-side counterpart of the retention distortion channel. Accepts the distorted threshold-voltage stream and the original programmed level of each cell.
- Buffers samples in a small FIFO, then resolves each sample with a two-step sequential sense against three read references, the way an MLC page read does.
- Emits the detected level and its Gray-coded bits.
- Counts cells and raw bit errors for BER measurement.

---
 rtl/flash_read_detector.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/flash_read_detector.sv
// MLC read-side detector: buffers distorted Vth samples, resolves each with a
// two-step sense against three read references, and accumulates cell/bit-error counts.
module flash_read_detector #(
    parameter logic [15:0] REF1       = 16'h1000,
    parameter logic [15:0] REF2       = 16'h2000,
    parameter logic [15:0] REF3       = 16'h3000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inputValid,
    input  logic [15:0] inputVoltage,
    input  logic [1:0]  inputLevel,
    input  logic        clearCounters,
    output logic [1:0]  outputLevel,
    output logic [1:0]  outputBits,
    output logic        outputValid,
    output logic [31:0] cellCount,
    output logic [31:0] bitErrorCount,
    output logic        overflow
);

    // state | meaning
    // IDLE  | FIFO empty, waiting for a sample
    // MID   | compare against the middle reference (high bit)
    // SIDE  | compare against REF1 or REF3 (low bit), emit result
    typedef enum logic [1:0] {IDLE, MID, SIDE} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);

    function automatic logic [1:0] gray_map(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 2'b11;
            2'd1:    return 2'b10;
            2'd2:    return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    logic [17:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    state_t        r_state;
    logic [15:0]   r_v;
    logic [1:0]    r_tag;
    logic          r_hi;
    logic [1:0]    r_exp_bits;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_lo;
    logic [17:0]   w_head;
    logic [1:0]    w_diff;
    logic [32:0]   w_err_sum;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && ((r_state == IDLE) || (r_state == SIDE));
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign w_push  = inputValid && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_lo    = r_hi ? (r_v >= REF3) : (r_v >= REF1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {inputLevel, inputVoltage};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (inputValid && !w_push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_v         <= '0;
            r_tag       <= '0;
            r_hi        <= 1'b0;
            r_exp_bits  <= '0;
            outputLevel <= '0;
            outputBits  <= '0;
            outputValid <= 1'b0;
        end else begin
            outputValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_v     <= w_head[15:0];
                        r_tag   <= w_head[17:16];
                        r_state <= MID;
                    end
                end
                MID: begin
                    r_hi    <= (r_v >= REF2);
                    r_state <= SIDE;
                end
                SIDE: begin
                    outputLevel <= {r_hi, w_lo};
                    outputBits  <= gray_map({r_hi, w_lo});
                    r_exp_bits  <= gray_map(r_tag);
                    outputValid <= 1'b1;
                    if (w_pop) begin
                        r_v     <= w_head[15:0];
                        r_tag   <= w_head[17:16];
                        r_state <= MID;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Counters consume the registered result during the outputValid cycle.
    assign w_diff    = outputBits ^ r_exp_bits;
    assign w_err_sum = {1'b0, bitErrorCount} + {31'd0, w_diff[1]} + {31'd0, w_diff[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cellCount     <= '0;
            bitErrorCount <= '0;
        end else if (clearCounters) begin
            cellCount     <= '0;
            bitErrorCount <= '0;
        end else if (outputValid) begin
            if (cellCount != 32'hFFFF_FFFF) begin
                cellCount <= cellCount + 32'd1;
            end
            bitErrorCount <= w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];
        end
    end

endmodule
